// File: rtl/tnet_axi_regbank.sv
// tnet_axi_regbank: AXI4-Lite slave exposing N_RW control registers and N_RO status
// registers, with byte-strobe writes, self-clearing command registers and access pulses.
module tnet_axi_regbank #(
   parameter int              ADDR_W       = 8,
   parameter int              N_RW         = 8,
   parameter int              N_RO         = 8,
   parameter logic [N_RW-1:0] AUTOCLR_MASK = {N_RW{1'b0}}
) (
   input  logic                 ps_aclk,
   input  logic                 ps_areset,
   input  logic [ADDR_W-1:0]    s_awaddr,
   input  logic                 s_awvalid,
   output logic                 s_awready,
   input  logic [31:0]          s_wdata,
   input  logic [3:0]           s_wstrb,
   input  logic                 s_wvalid,
   output logic                 s_wready,
   output logic [1:0]           s_bresp,
   output logic                 s_bvalid,
   input  logic                 s_bready,
   input  logic [ADDR_W-1:0]    s_araddr,
   input  logic                 s_arvalid,
   output logic                 s_arready,
   output logic [31:0]          s_rdata,
   output logic [1:0]           s_rresp,
   output logic                 s_rvalid,
   input  logic                 s_rready,
   output logic [32*N_RW-1:0]   rw_regs,
   output logic [N_RW-1:0]      rw_wr_pulse,
   input  logic [32*N_RO-1:0]   ro_regs,
   output logic [N_RO-1:0]      ro_rd_pulse
);

   localparam int IDX_W = ADDR_W - 2;

   if ((N_RW < 1) || (N_RW > 32) || (N_RO < 1) || (N_RO > 32) ||
       ((N_RW + N_RO) > (1 << IDX_W))) begin : g_bad_params
      $error("tnet_axi_regbank: register count does not fit the address space");
   end

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_WAIT_D = 2'd1,
      W_WAIT_A = 2'd2,
      W_RESP   = 2'd3
   } wstate_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } rstate_t;

   wstate_t             wstate_q, wstate_d;
   logic                awready_q, awready_d;
   logic                wready_q, wready_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [IDX_W-1:0]    awidx_q, awidx_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [32*N_RW-1:0]  rw_q, rw_d, rw_base_s;
   logic [N_RW-1:0]     wr_pulse_q, wr_pulse_d;

   logic                aw_hs_s, w_hs_s, commit_s;
   logic [IDX_W-1:0]    cm_idx_s;
   logic [31:0]         cm_data_s;
   logic [3:0]          cm_strb_s;
   logic [N_RW-1:0]     wsel_s;

   rstate_t             rstate_q, rstate_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [N_RO-1:0]     rd_pulse_q, rd_pulse_d;

   logic                ar_hs_s, rd_hit_s;
   logic [IDX_W-1:0]    rd_idx_s;
   logic [31:0]         rd_word_s;
   logic [N_RW-1:0]     rsel_rw_s;
   logic [N_RO-1:0]     rsel_ro_s;

   logic                unused_addr_lsbs;

   assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

   assign aw_hs_s = s_awvalid & awready_q;
   assign w_hs_s  = s_wvalid & wready_q;
   assign ar_hs_s = s_arvalid & arready_q;

   // Write FSM: the commit happens on the edge where the second half arrives.
   always_comb begin
      wstate_d  = wstate_q;
      awidx_d   = awidx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      commit_s  = 1'b0;
      cm_idx_s  = awidx_q;
      cm_data_s = wdata_q;
      cm_strb_s = wstrb_q;
      case (wstate_q)
         W_IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               commit_s  = 1'b1;
               cm_idx_s  = s_awaddr[ADDR_W-1:2];
               cm_data_s = s_wdata;
               cm_strb_s = s_wstrb;
               wstate_d  = W_RESP;
            end else if (aw_hs_s) begin
               awidx_d  = s_awaddr[ADDR_W-1:2];
               wstate_d = W_WAIT_D;
            end else if (w_hs_s) begin
               wdata_d  = s_wdata;
               wstrb_d  = s_wstrb;
               wstate_d = W_WAIT_A;
            end else begin
               wstate_d = W_IDLE;
            end
         end
         W_WAIT_D: begin
            if (w_hs_s) begin
               commit_s  = 1'b1;
               cm_idx_s  = awidx_q;
               cm_data_s = s_wdata;
               cm_strb_s = s_wstrb;
               wstate_d  = W_RESP;
            end else begin
               wstate_d = W_WAIT_D;
            end
         end
         W_WAIT_A: begin
            if (aw_hs_s) begin
               commit_s  = 1'b1;
               cm_idx_s  = s_awaddr[ADDR_W-1:2];
               cm_data_s = wdata_q;
               cm_strb_s = wstrb_q;
               wstate_d  = W_RESP;
            end else begin
               wstate_d = W_WAIT_A;
            end
         end
         W_RESP: begin
            if (s_bready) begin
               wstate_d = W_IDLE;
            end else begin
               wstate_d = W_RESP;
            end
         end
         default: begin
            wstate_d = W_IDLE;
         end
      endcase
      awready_d = (wstate_d == W_IDLE) || (wstate_d == W_WAIT_A);
      wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_WAIT_D);
      bvalid_d  = (wstate_d == W_RESP);
   end

   // Decode the committed index against each control register.
   always_comb begin
      wsel_s = {N_RW{1'b0}};
      for (int i = 0; i < N_RW; i++) begin
         wsel_s[i] = commit_s && (cm_idx_s == IDX_W'(i));
      end
   end

   // Control register update; command registers fall back to zero when not being written.
   always_comb begin
      rw_base_s  = {32*N_RW{1'b0}};
      rw_d       = {32*N_RW{1'b0}};
      wr_pulse_d = wsel_s;
      for (int i = 0; i < N_RW; i++) begin
         rw_base_s[32*i +: 32] = AUTOCLR_MASK[i] ? 32'h0000_0000 : rw_q[32*i +: 32];
         for (int k = 0; k < 4; k++) begin
            rw_d[32*i+8*k +: 8] = (wsel_s[i] && cm_strb_s[k]) ? cm_data_s[8*k +: 8]
                                                              : rw_base_s[32*i+8*k +: 8];
         end
      end
      if (commit_s) begin
         bresp_d = (|wsel_s) ? 2'b00 : 2'b10;
      end else begin
         bresp_d = bresp_q;
      end
   end

   // Write-side state and outputs.
   always_ff @(posedge ps_aclk) begin
      if (ps_areset) begin
         wstate_q   <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         awidx_q    <= {IDX_W{1'b0}};
         wdata_q    <= 32'h0000_0000;
         wstrb_q    <= 4'h0;
         rw_q       <= {32*N_RW{1'b0}};
         wr_pulse_q <= {N_RW{1'b0}};
      end else begin
         wstate_q   <= wstate_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         awidx_q    <= awidx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         rw_q       <= rw_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   assign rd_idx_s = s_araddr[ADDR_W-1:2];

   // Read mux built as an AND-OR over one-hot selects; unmapped indices yield zero.
   always_comb begin
      rsel_rw_s = {N_RW{1'b0}};
      rsel_ro_s = {N_RO{1'b0}};
      rd_word_s = 32'h0000_0000;
      for (int i = 0; i < N_RW; i++) begin
         rsel_rw_s[i] = (rd_idx_s == IDX_W'(i));
         rd_word_s    = rd_word_s | ({32{rsel_rw_s[i]}} & rw_q[32*i +: 32]);
      end
      for (int j = 0; j < N_RO; j++) begin
         rsel_ro_s[j] = (rd_idx_s == IDX_W'(N_RW + j));
         rd_word_s    = rd_word_s | ({32{rsel_ro_s[j]}} & ro_regs[32*j +: 32]);
      end
      rd_hit_s = (|rsel_rw_s) | (|rsel_ro_s);
   end

   // Read FSM: data and response are captured at the accept edge and held until rready.
   always_comb begin
      rstate_d   = rstate_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rd_pulse_d = {N_RO{1'b0}};
      case (rstate_q)
         R_IDLE: begin
            if (ar_hs_s) begin
               rstate_d   = R_RESP;
               rdata_d    = rd_word_s;
               rresp_d    = rd_hit_s ? 2'b00 : 2'b10;
               rd_pulse_d = rsel_ro_s;
            end else begin
               rstate_d = R_IDLE;
            end
         end
         R_RESP: begin
            if (s_rready) begin
               rstate_d = R_IDLE;
            end else begin
               rstate_d = R_RESP;
            end
         end
         default: begin
            rstate_d = R_IDLE;
         end
      endcase
      arready_d = (rstate_d == R_IDLE);
      rvalid_d  = (rstate_d == R_RESP);
   end

   // Read-side state and outputs.
   always_ff @(posedge ps_aclk) begin
      if (ps_areset) begin
         rstate_q   <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'h0000_0000;
         rresp_q    <= 2'b00;
         rd_pulse_q <= {N_RO{1'b0}};
      end else begin
         rstate_q   <= rstate_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rd_pulse_q <= rd_pulse_d;
      end
   end

   assign s_awready   = awready_q;
   assign s_wready    = wready_q;
   assign s_bvalid    = bvalid_q;
   assign s_bresp     = bresp_q;
   assign s_arready   = arready_q;
   assign s_rvalid    = rvalid_q;
   assign s_rdata     = rdata_q;
   assign s_rresp     = rresp_q;
   assign rw_regs     = rw_q;
   assign rw_wr_pulse = wr_pulse_q;
   assign ro_rd_pulse = rd_pulse_q;

endmodule

// File: doc/tnet_axi_regbank.md
Name: tnet_axi_regbank

Overview:
Parametrised AXI4-Lite slave register bank for the tnet network block. It replaces fixed-map register slaves with a configurable bank of N_RW control registers and N_RO status registers. It adds byte-strobe writes, auto-clearing command registers, per-register write and read pulses, and SLVERR on unmapped addresses. It sits between the PS AXI-Lite interconnect and the tnet core, which consumes the control words and supplies the status words.

Parameters:
ADDR_W, 8, AXI byte-address width; register index = addr[ADDR_W-1:2], addr[1:0] ignored
N_RW, 8, number of read/write control registers, indices 0..N_RW-1 (1..32)
N_RO, 8, number of read-only status registers, indices N_RW..N_RW+N_RO-1 (1..32)
AUTOCLR_MASK, 0, N_RW-bit mask; bit i=1 makes RW register i a self-clearing command register
Constraint: N_RW+N_RO <= 2**(ADDR_W-2), checked at elaboration

Ports:
ps_aclk  in  1  single clock for the whole block
ps_areset  in  1  synchronous reset, active-high
s_awaddr  in  ADDR_W  write address
s_awvalid / s_awready  in / out  1  write-address handshake
s_wdata  in  32  write data
s_wstrb  in  4  byte enables
s_wvalid / s_wready  in / out  1  write-data handshake
s_bresp  out  2  write response: 00 OKAY, 10 SLVERR
s_bvalid / s_bready  out / in  1  write-response handshake
s_araddr  in  ADDR_W  read address
s_arvalid / s_arready  in / out  1  read-address handshake
s_rdata  out  32  read data
s_rresp  out  2  read response: 00 OKAY, 10 SLVERR
s_rvalid / s_rready  out / in  1  read-data handshake
rw_regs  out  32*N_RW  flattened control registers; register i at [32*i+31:32*i]
rw_wr_pulse  out  N_RW  1-cycle pulse per committed write to register i
ro_regs  in  32*N_RO  flattened status inputs
ro_rd_pulse  out  N_RO  1-cycle pulse per accepted read of status register j

Behaviour:
- Reset (ps_areset=1 at an edge) forces every output to 0: rw_regs, pulses, all ready/valid signals, bresp, rresp and rdata. Write and read FSMs return to IDLE. Any in-flight transaction is dropped; no response is issued for it. Ready signals first assert in the cycle after reset deasserts.
- Write FSM states and ready signals:
  - W_IDLE: awready=1, wready=1.
  - W_WAIT_D: awready=0, wready=1.
  - W_WAIT_A: awready=1, wready=0.
  - W_RESP: awready=0, wready=0, bvalid=1.
- Write transitions:
  - W_IDLE, awvalid and wvalid both high: commit at this edge, go to W_RESP.
  - W_IDLE, awvalid only: latch address, go to W_WAIT_D.
  - W_IDLE, wvalid only: latch data and strobes, go to W_WAIT_A.
  - W_WAIT_D/W_WAIT_A: commit at the edge where the missing half is accepted, go to W_RESP.
  - W_RESP: hold bvalid and bresp stable until bready; return to W_IDLE on that edge.
- Only one write is outstanding at a time.
- Commit:
  - Index < N_RW: each byte k with wstrb[k]=1 is updated; other bytes hold. bresp=00. rw_wr_pulse[i]=1 in the cycle after the commit edge, the same cycle the new value is visible on rw_regs.
  - Index >= N_RW (RO or unmapped): no state change, no pulse, bresp=10.
  - wstrb=0000 to a valid RW index: no data change, pulse still fires, bresp=00.
- Autoclear: if AUTOCLR_MASK[i]=1, register i shows the written value for exactly one cycle (concurrent with rw_wr_pulse[i]), then returns to 0. Back-to-back commits are at least 2 cycles apart, so the clear never collides with a new write.
- Read FSM: R_IDLE (arready=1) and R_RESP (arready=0, rvalid=1).
  - On arvalid in R_IDLE: rdata/rresp are registered at the accept edge, rvalid=1 from the next cycle.
  - rdata and rresp hold until rready; return to R_IDLE on that edge.
  - Latency from arvalid to rvalid is 1 cycle.
- Read data by index:
  - RW index: current rw_regs value (pre-commit value if a write commits on the same edge).
  - RO index: ro_regs sampled at the accept edge; ro_rd_pulse[j]=1 in the next cycle.
  - Unmapped index: rdata=0, rresp=10, no pulse.
- The read and write channels are fully independent and may complete in the same cycle.
- s_awaddr[1:0] and s_araddr[1:0] are ignored; unaligned addresses access the containing word.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x04 (reg 1), wstrb=F, aw and w in the same cycle -> bvalid 1 cycle later, bresp=00; rw_regs[1]=0xDEADBEEF; rw_wr_pulse=0x02 for 1 cycle; readback of 0x04 returns 0xDEADBEEF with rresp=00.
- W three cycles before AW, then byte write 0x000000AA with wstrb=0001 to reg 1 -> FSM passes W_WAIT_A; rw_regs[1]=0xDEADBEAA; bvalid held for 4 cycles while bready=0, then drops 1 cycle after bready.
- AUTOCLR_MASK=0x01, write 0x1 to reg 0 -> rw_regs[0]=1 for exactly 1 cycle, coincident with rw_wr_pulse[0], then 0.
- ro_regs[2]=0x12345678 (index N_RW+2, addr 0x28 with defaults); read it -> rdata=0x12345678, ro_rd_pulse=0x04 for 1 cycle; write to 0x28 -> bresp=10, no state change.
- Read and write to 0xFC (unmapped) -> rresp=10 with rdata=0; bresp=10; no pulses.
- Assert ps_areset while in W_WAIT_D and R_RESP -> next cycle all outputs 0; no bvalid ever issued for the dropped write; a fresh write after release completes normally.
